imem_program_loader: RTL and testbench
======================================

Name: imem_program_loader

Overview:
- Producer end of the instruction-memory interface. Receives a framed byte stream over a valid/ready handshake and assembles 16-bit instructions ({opcode[3:0], rs1[3:0], rs2[3:0], rd[3:0]}).
- Writes each instruction into instruction memory through a single write port.
- Holds the processor core in reset until a complete frame with a valid checksum has been loaded.
- Sits between the host/debug link and pipeline_processor instruction memory, replacing hierarchical bench preloads.

Parameters:
- ADDR_W, 4, instruction-memory address width.
- IMEM_DEPTH, 16, maximum instruction count per frame (≤ 2^ADDR_W).
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT, 255, maximum idle cycles allowed between bytes inside a frame.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader can accept a byte; transfer occurs when in_valid && in_ready at a clk edge
- err_clr  in  1  single-cycle pulse; clears the error state
- imem_we  out  1  instruction-memory write strobe, one cycle per word
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  16  instruction word
- core_hold  out  1  high = processor must be held in reset
- load_done  out  1  level; frame loaded and verified
- load_err  out  1  level; frame rejected
- err_code  out  2  00 none, 01 bad count, 10 checksum mismatch, 11 timeout

Behaviour:
- Reset values (clock edge with reset=1):
  - imem_we=0, imem_addr=0, imem_wdata=0.
  - core_hold=1, load_done=0, load_err=0, err_code=00, in_ready=0.
  - State=IDLE, checksum accumulator=0, word counter=0, timeout counter=0.
- in_ready: 1 from the first cycle after reset deasserts, in every state except ERR. Bytes presented while in_ready=0 are not consumed.
- States:
  - IDLE: accepted byte == SYNC_BYTE → COUNT, set core_hold=1, clear load_done. Any other byte is discarded.
  - COUNT: accepted byte N.
    - N==0 or N>IMEM_DEPTH → ERR, err_code=01.
    - Otherwise latch N, set csum=N, word counter=0 → HI.
  - HI: accepted byte latched as wdata[15:8], csum^=byte → LO.
  - LO: accepted byte latched as wdata[7:0], csum^=byte.
    - Next cycle: imem_we=1, imem_addr=word counter, imem_wdata=assembled word.
    - Word counter then increments.
    - Counter reaches N → CHECK; otherwise → HI.
  - CHECK: accepted byte == csum → DONE; otherwise → ERR, err_code=10.
  - DONE: load_done=1, core_hold=0 (both registered, asserted in the cycle after the checksum byte is accepted).
    - An accepted SYNC_BYTE restarts the loader: → COUNT, core_hold=1, load_done=0.
    - Any other byte is discarded.
  - ERR: load_err=1, core_hold=1, in_ready=0. err_clr → IDLE, load_err=0, err_code=00.
- Write latency: exactly 1 cycle from acceptance of the LO byte to imem_we. The strobe lasts 1 cycle. imem_addr and imem_wdata hold their values after the strobe.
- Back-to-back bytes (in_valid held high continuously) are accepted every cycle with no stall. The pending write never conflicts with the next byte.
- Timeout:
  - In COUNT, HI, LO and CHECK, the counter increments on every cycle with no transfer and clears on every transfer.
  - Reaching TIMEOUT → ERR, err_code=11.
  - No timeout in IDLE or DONE.
- Words already written before an error remain in memory; core_hold stays 1.
- Simultaneous err_clr and in_valid in ERR: the clear wins and the byte is not consumed (in_ready=0).
- Reset mid-frame: abort immediately, return to reset values, issue no further write. Partial memory contents are left as-is.
- Address never wraps: the N ≤ IMEM_DEPTH check guarantees addresses 0..N-1.
- Checksum: 8-bit XOR over the count byte and all 2N payload bytes. SYNC_BYTE is excluded.

Test Plan:
- Valid load. Stream A5 05 11 23 21 24 31 05 41 20 00 00 67, back-to-back.
  - Required: writes addr0=0x1123, 1=0x2124, 2=0x3105, 3=0x4120, 4=0x0000, each 1 cycle after its LO byte.
  - Required: load_done=1 and core_hold=0 one cycle after 0x67.
- Checksum error. Same frame with last byte 0x66.
  - Required: all 5 writes occur, then load_err=1, err_code=10, core_hold=1, in_ready=0.
  - Then pulse err_clr → load_err=0, in_ready=1, state IDLE.
- Bad count. Stream A5 00 → err_code=01, no writes. After err_clr, stream A5 11 (17 > 16) → err_code=01.
- Timeout with throttling.
  - Valid frame with in_valid dropped 3 cycles between bytes → loads correctly.
  - Stall 255 cycles after an HI byte → err_code=11.
- Resync and reload:
  - Garbage bytes 00 FF 12 before A5 are ignored.
  - After DONE, a new frame A5 01 00 00 01 → core_hold rises on the SYNC accept, 0x0000 is written to addr0, load_done returns to 1.
- Reset mid-frame. Assert reset after the 2nd word is written → outputs return to reset values, no third write.
  - A subsequent full valid frame loads correctly.

Source files
------------

// File: rtl/imem_program_loader.sv
// imem_program_loader: framed byte-stream loader that writes 16-bit words to instruction memory and holds the core until a checksum-verified frame is loaded
module imem_program_loader #(
  parameter int ADDR_W = 4,
  parameter int IMEM_DEPTH = 16,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic reset,
  input logic [7:0] in_data,
  input logic in_valid,
  output logic in_ready,
  input logic err_clr,
  output logic imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0] imem_wdata,
  output logic core_hold,
  output logic load_done,
  output logic load_err,
  output logic [1:0] err_code
);
  localparam int CW = $clog2(IMEM_DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, COUNT, HI, LO, CHECK, DONE, ERR} state_t;
  state_t state_q, state_d;
  logic [7:0] csum_q, csum_d, hi_q, hi_d;
  logic [CW-1:0] n_q, n_d, cnt_q, cnt_d, cnt_inc;
  logic [TW-1:0] tmo_q, tmo_d;
  logic imem_we_q, imem_we_d, core_hold_q, core_hold_d, load_done_q, load_done_d;
  logic load_err_q, load_err_d, in_ready_q, in_ready_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [15:0] imem_wdata_q, imem_wdata_d;
  logic [1:0] err_code_q, err_code_d;
  logic fire;
  assign fire = in_valid & in_ready_q;
  assign cnt_inc = cnt_q + 1'b1;
  always_comb begin
    state_d = state_q;
    csum_d = csum_q;
    hi_d = hi_q;
    n_d = n_q;
    cnt_d = cnt_q;
    tmo_d = '0;
    imem_we_d = 1'b0;
    imem_addr_d = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    core_hold_d = core_hold_q;
    load_done_d = load_done_q;
    load_err_d = load_err_q;
    err_code_d = err_code_q;
    case (state_q)
      IDLE, DONE: if (fire && in_data == SYNC_BYTE) begin
        state_d = COUNT;
        core_hold_d = 1'b1;
        load_done_d = 1'b0;
      end
      COUNT: if (fire) begin
        if (in_data == 8'h00 || int'(in_data) > IMEM_DEPTH) begin
          state_d = ERR;
          load_err_d = 1'b1;
          err_code_d = 2'b01;
        end else begin
          state_d = HI;
          n_d = CW'(in_data);
          csum_d = in_data;
          cnt_d = '0;
        end
      end
      HI: if (fire) begin
        state_d = LO;
        hi_d = in_data;
        csum_d = csum_q ^ in_data;
      end
      LO: if (fire) begin
        state_d = (cnt_inc == n_q) ? CHECK : HI;
        csum_d = csum_q ^ in_data;
        imem_we_d = 1'b1;
        imem_addr_d = ADDR_W'(cnt_q);
        imem_wdata_d = {hi_q, in_data};
        cnt_d = cnt_inc;
      end
      CHECK: if (fire) begin
        if (in_data == csum_q) begin
          state_d = DONE;
          load_done_d = 1'b1;
          core_hold_d = 1'b0;
        end else begin
          state_d = ERR;
          load_err_d = 1'b1;
          err_code_d = 2'b10;
        end
      end
      ERR: if (err_clr) begin
        state_d = IDLE;
        load_err_d = 1'b0;
        err_code_d = 2'b00;
      end
      default: state_d = IDLE;
    endcase
    if (state_q inside {COUNT, HI, LO, CHECK} && !fire) begin
      tmo_d = tmo_q + 1'b1;
      if (tmo_q == TW'(TIMEOUT - 1)) begin
        state_d = ERR;
        load_err_d = 1'b1;
        err_code_d = 2'b11;
      end
    end
    in_ready_d = state_d != ERR;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      csum_q <= '0;
      hi_q <= '0;
      n_q <= '0;
      cnt_q <= '0;
      tmo_q <= '0;
      imem_we_q <= 1'b0;
      imem_addr_q <= '0;
      imem_wdata_q <= '0;
      core_hold_q <= 1'b1;
      load_done_q <= 1'b0;
      load_err_q <= 1'b0;
      err_code_q <= 2'b00;
      in_ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      csum_q <= csum_d;
      hi_q <= hi_d;
      n_q <= n_d;
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
      imem_we_q <= imem_we_d;
      imem_addr_q <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      core_hold_q <= core_hold_d;
      load_done_q <= load_done_d;
      load_err_q <= load_err_d;
      err_code_q <= err_code_d;
      in_ready_q <= in_ready_d;
    end
  end
  assign in_ready = in_ready_q;
  assign imem_we = imem_we_q;
  assign imem_addr = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_hold = core_hold_q;
  assign load_done = load_done_q;
  assign load_err = load_err_q;
  assign err_code = err_code_q;
endmodule

// File: tb/tb_imem_program_loader.sv
// tb_imem_program_loader: scoreboard bench driving framed byte streams into imem_program_loader
module tb_imem_program_loader;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic in_valid = 1'b0;
  logic in_ready;
  logic err_clr = 1'b0;
  logic imem_we;
  logic [3:0] imem_addr;
  logic [15:0] imem_wdata;
  logic core_hold, load_done, load_err;
  logic [1:0] err_code;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int exp_a[$];
  int exp_d[$];
  int exp_c[$];
  logic [7:0] fb[$];
  logic [15:0] last_w;
  int ma, md, mc;

  imem_program_loader dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .err_clr(err_clr), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_hold(core_hold), .load_done(load_done), .load_err(load_err), .err_code(err_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (imem_we) begin
      checks++;
      if (exp_a.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write got addr=%0h data=%04h cyc=%0d required no write", imem_addr, imem_wdata, cyc);
      end else begin
        ma = exp_a.pop_front();
        md = exp_d.pop_front();
        mc = exp_c.pop_front();
        if (int'(imem_addr) != ma || int'(imem_wdata) != md || cyc != mc) begin
          failures++;
          $display("FAIL write got addr=%0h data=%04h cyc=%0d required addr=%0h data=%04h cyc=%0d",
                   imem_addr, imem_wdata, cyc, ma, md, mc);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int w;
    in_data = b;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int gap, input int nbytes);
    int n, w;
    n = (fb.size() > 1) ? int'(fb[1]) : 0;
    for (int i = 0; i < nbytes; i++) begin
      in_data = fb[i];
      in_valid = 1'b1;
      w = 0;
      while (!in_ready && w < 50) begin
        @(negedge clk);
        w++;
      end
      checks++;
      if (w != 0) begin
        failures++;
        $display("FAIL stall byte=%0d got wait=%0d required 0", i, w);
      end
      if (i >= 3 && (i % 2) == 1 && n >= 1 && n <= 16 && (i - 3) / 2 < n) begin
        exp_a.push_back((i - 3) / 2);
        exp_d.push_back(int'({fb[i-1], fb[i]}));
        exp_c.push_back(cyc + 1);
      end
      @(negedge clk);
      if (i == 0) begin
        checks++;
        if (core_hold !== 1'b1 || load_done !== 1'b0) begin
          failures++;
          $display("FAIL sync_accept got hold=%b done=%b required hold=1 done=0", core_hold, load_done);
        end
      end
      if (gap > 0) begin
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic build_frame(input int n, input int seed);
    logic [7:0] cs;
    logic [15:0] w;
    fb.delete();
    fb.push_back(8'hA5);
    fb.push_back(8'(n));
    cs = 8'(n);
    for (int i = 0; i < n; i++) begin
      w = {4'(i), 4'(i + seed), 4'(15 - i), 4'(i ^ seed)};
      fb.push_back(w[15:8]);
      fb.push_back(w[7:0]);
      cs = cs ^ w[15:8] ^ w[7:0];
      last_w = w;
    end
    fb.push_back(cs);
  endtask

  task automatic clear_err(input logic with_byte);
    err_clr = 1'b1;
    in_valid = with_byte;
    in_data = 8'hA5;
    @(negedge clk);
    err_clr = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (load_err !== 1'b0 || err_code !== 2'b00 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL err_clr got err=%b code=%b ready=%b required err=0 code=00 ready=1", load_err, err_code, in_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (imem_we !== 1'b0 || imem_addr !== 4'h0 || imem_wdata !== 16'h0000) begin
      failures++;
      $display("FAIL reset_write_port got we=%b addr=%0h data=%04h required 0/0/0000", imem_we, imem_addr, imem_wdata);
    end
    checks++;
    if (core_hold !== 1'b1 || load_done !== 1'b0 || load_err !== 1'b0 || err_code !== 2'b00 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_status got hold=%b done=%b err=%b code=%b ready=%b required 1/0/0/00/0",
               core_hold, load_done, load_err, err_code, in_ready);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_reset got %b required 1", in_ready);
    end
  endtask

  task automatic test_valid_load();
    fb = '{8'hA5, 8'h05, 8'h11, 8'h23, 8'h21, 8'h24, 8'h31, 8'h05, 8'h41, 8'h20, 8'h00, 8'h00, 8'h67};
    send_frame(0, 13);
    checks++;
    if (load_done !== 1'b1 || core_hold !== 1'b0 || load_err !== 1'b0) begin
      failures++;
      $display("FAIL valid_done got done=%b hold=%b err=%b required 1/0/0", load_done, core_hold, load_err);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (imem_we !== 1'b0 || imem_addr !== 4'h4 || imem_wdata !== 16'h0000) begin
      failures++;
      $display("FAIL write_hold got we=%b addr=%0h data=%04h required 0/4/0000", imem_we, imem_addr, imem_wdata);
    end
    checks++;
    if (exp_a.size() != 0) begin
      failures++;
      $display("FAIL valid_pending got %0d required 0", exp_a.size());
    end
  endtask

  task automatic test_checksum_err();
    fb = '{8'hA5, 8'h05, 8'h11, 8'h23, 8'h21, 8'h24, 8'h31, 8'h05, 8'h41, 8'h20, 8'h00, 8'h00, 8'h66};
    send_frame(0, 13);
    checks++;
    if (load_err !== 1'b1 || err_code !== 2'b10 || core_hold !== 1'b1 || in_ready !== 1'b0 || load_done !== 1'b0) begin
      failures++;
      $display("FAIL csum_err got err=%b code=%b hold=%b ready=%b done=%b required 1/10/1/0/0",
               load_err, err_code, core_hold, in_ready, load_done);
    end
    checks++;
    if (exp_a.size() != 0) begin
      failures++;
      $display("FAIL csum_pending got %0d required 0", exp_a.size());
    end
    clear_err(1'b1);
    send(8'h00);
    checks++;
    if (load_err !== 1'b0) begin
      failures++;
      $display("FAIL clear_wins got err=%b required 0", load_err);
    end
  endtask

  task automatic test_bad_count();
    fb = '{8'hA5, 8'h00};
    send_frame(0, 2);
    checks++;
    if (load_err !== 1'b1 || err_code !== 2'b01) begin
      failures++;
      $display("FAIL count_zero got err=%b code=%b required 1/01", load_err, err_code);
    end
    clear_err(1'b0);
    fb = '{8'hA5, 8'h11};
    send_frame(0, 2);
    checks++;
    if (load_err !== 1'b1 || err_code !== 2'b01 || core_hold !== 1'b1) begin
      failures++;
      $display("FAIL count_17 got err=%b code=%b hold=%b required 1/01/1", load_err, err_code, core_hold);
    end
    clear_err(1'b0);
  endtask

  task automatic test_throttle();
    build_frame(3, 6);
    send_frame(3, int'(fb.size()));
    checks++;
    if (load_done !== 1'b1 || core_hold !== 1'b0 || load_err !== 1'b0 || exp_a.size() != 0) begin
      failures++;
      $display("FAIL throttle got done=%b hold=%b err=%b pending=%0d required 1/0/0/0",
               load_done, core_hold, load_err, exp_a.size());
    end
  endtask

  task automatic test_timeout();
    int k;
    fb = '{8'hA5, 8'h02, 8'h12};
    send_frame(0, 3);
    k = 0;
    while (!load_err && k < 400) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k != 255) begin
      failures++;
      $display("FAIL timeout_cycles got %0d required 255", k);
    end
    checks++;
    if (err_code !== 2'b11 || core_hold !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL timeout_status got code=%b hold=%b ready=%b required 11/1/0", err_code, core_hold, in_ready);
    end
    clear_err(1'b0);
  endtask

  task automatic test_resync_reload();
    send(8'h00);
    send(8'hFF);
    send(8'h12);
    fb = '{8'hA5, 8'h05, 8'h11, 8'h23, 8'h21, 8'h24, 8'h31, 8'h05, 8'h41, 8'h20, 8'h00, 8'h00, 8'h67};
    send_frame(0, 13);
    checks++;
    if (load_done !== 1'b1 || core_hold !== 1'b0) begin
      failures++;
      $display("FAIL resync_done got done=%b hold=%b required 1/0", load_done, core_hold);
    end
    repeat (300) @(negedge clk);
    checks++;
    if (load_err !== 1'b0 || load_done !== 1'b1 || core_hold !== 1'b0) begin
      failures++;
      $display("FAIL done_idle got err=%b done=%b hold=%b required 0/1/0", load_err, load_done, core_hold);
    end
    fb = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h01};
    send_frame(0, 5);
    checks++;
    if (load_done !== 1'b1 || core_hold !== 1'b0 || exp_a.size() != 0) begin
      failures++;
      $display("FAIL reload got done=%b hold=%b pending=%0d required 1/0/0", load_done, core_hold, exp_a.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    fb = '{8'hA5, 8'h05, 8'h11, 8'h23, 8'h21, 8'h24, 8'h31, 8'h05, 8'h41, 8'h20, 8'h00, 8'h00, 8'h67};
    send_frame(0, 6);
    reset = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h31;
    repeat (2) @(negedge clk);
    checks++;
    if (imem_we !== 1'b0 || imem_addr !== 4'h0 || imem_wdata !== 16'h0000 || core_hold !== 1'b1 ||
        load_done !== 1'b0 || load_err !== 1'b0 || err_code !== 2'b00 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got we=%b addr=%0h data=%04h hold=%b done=%b err=%b code=%b ready=%b required 0/0/0000/1/0/0/00/0",
               imem_we, imem_addr, imem_wdata, core_hold, load_done, load_err, err_code, in_ready);
    end
    in_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (exp_a.size() != 0) begin
      failures++;
      $display("FAIL mid_reset_pending got %0d required 0", exp_a.size());
    end
    send_frame(0, 13);
    checks++;
    if (load_done !== 1'b1 || core_hold !== 1'b0 || exp_a.size() != 0) begin
      failures++;
      $display("FAIL after_reset_load got done=%b hold=%b pending=%0d required 1/0/0", load_done, core_hold, exp_a.size());
    end
  endtask

  task automatic test_max_count();
    build_frame(16, 9);
    send_frame(0, int'(fb.size()));
    @(negedge clk);
    checks++;
    if (load_done !== 1'b1 || imem_addr !== 4'hF || imem_wdata !== last_w || exp_a.size() != 0) begin
      failures++;
      $display("FAIL max_count got done=%b addr=%0h data=%04h pending=%0d required 1/f/%04h/0",
               load_done, imem_addr, imem_wdata, exp_a.size(), last_w);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_valid_load();
    test_checksum_err();
    test_bad_count();
    test_throttle();
    test_timeout();
    test_resync_reload();
    test_reset_mid_frame();
    test_max_count();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
